// File: rtl/usart_pkg.sv
// usart_pkg: shared constants and helpers for the oversampling USART blocks
package usart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;
  localparam int ENTRY_EXTRA = 2;
  function automatic int baud_div(int clk, int baud, int os);
    return clk / (baud * os);
  endfunction
  function automatic int entry_w(int db);
    return db + ENTRY_EXTRA;
  endfunction
endpackage

// File: rtl/usart_rx_os_if.sv
// usart_rx_os_if: valid/ready stream of received words with their error flags
interface usart_rx_os_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data_out;
  logic parity_err;
  logic frame_err;
  logic data_valid;
  logic data_ready;
  modport master(output data_out, parity_err, frame_err, data_valid, input data_ready);
  modport slave(input data_out, parity_err, frame_err, data_valid, output data_ready);
endinterface

// File: rtl/usart_sync_fifo.sv
// usart_sync_fifo: first-word-fall-through FIFO; head reads as zero while empty
module usart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/usart_rx_os.sv
// usart_rx_os: oversampling USART receiver with majority vote, error flags and FWFT buffer
module usart_rx_os
  import usart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  usart_rx_os_if.master rx_if,
  output logic overrun,
  output logic busy
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DW = $clog2(DIV + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = entry_w(DATA_BITS);
  localparam logic [TW-1:0] T_LO = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  if (DIV < 1) begin : g_bad_div
    $error("usart_rx_os: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) is below 1");
  end
  logic [1:0] sync;
  logic rxs, tick, dec, bend, vote, fbad, sidx, perr, ferr, push, pop, full, empty;
  logic [DW-1:0] div_cnt;
  logic [2:0] state;
  logic [TW-1:0] tcnt;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] sh;
  logic [BW-1:0] bidx;
  logic [EW-1:0] head;
  assign rxs = sync[1];
  assign tick = div_cnt == DW'(DIV - 1);
  assign dec = tick && tcnt == T_HI;
  assign bend = tick && tcnt == T_END;
  assign vote = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
  assign fbad = ferr | ~vote;
  assign busy = state != S_IDLE;
  assign pop = rx_if.data_valid && rx_if.data_ready;
  assign rx_if.data_valid = !empty;
  assign {rx_if.frame_err, rx_if.parity_err, rx_if.data_out} = head;
  assign overrun = push && full && !rx_if.data_ready;
  always_ff @(posedge clk) sync <= reset ? 2'b11 : {sync[0], rx};
  // the divider restarts on the start edge so ticks line up with the incoming frame
  always_ff @(posedge clk) div_cnt <= (reset || tick || (state == S_IDLE && !rxs)) ? '0 : div_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      tcnt <= '0;
      smp <= '0;
      sh <= '0;
      bidx <= '0;
      sidx <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      push <= 1'b0;
    end else begin
      push <= 1'b0;
      if (tick) tcnt <= bend ? '0 : tcnt + 1'b1;
      if (tick && tcnt == T_LO) smp[0] <= rxs;
      if (tick && tcnt == T_MID) smp[1] <= rxs;
      case (state)
        S_IDLE: if (!rxs) begin
          state <= S_START;
          tcnt <= '0;
          bidx <= '0;
          sidx <= 1'b0;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        S_START: if (dec && vote) state <= S_IDLE; else if (bend) state <= S_DATA;
        S_DATA: begin
          if (dec) sh <= {vote, sh[DATA_BITS-1:1]};
          if (bend) begin
            bidx <= bidx + 1'b1;
            if (bidx == BW'(DATA_BITS - 1)) state <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (dec) perr <= vote != ((^sh) ^ (PARITY == PARITY_ODD));
          if (bend) state <= S_STOP;
        end
        // leaving at the decision tick of a good stop bit lets the next start edge be seen
        S_STOP: if (dec) begin
          ferr <= fbad;
          if (sidx == 1'(STOP_BITS - 1)) begin
            push <= 1'b1;
            state <= fbad ? S_WAIT_HIGH : S_IDLE;
          end
        end else if (bend) sidx <= sidx + 1'b1;
        S_WAIT_HIGH: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  usart_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({ferr, perr, sh}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_usart_rx_os.sv
// tb_usart_rx_os: 8N1 and 8E1 receivers driven by a bit-level line model and a word scoreboard
module tb_usart_rx_os;
  localparam int BIT = 160;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] rx, rdy, pe, fe, valid, ovr, busy;
  logic [7:0] dout [2];
  int mode [2];
  int errors = 0, checks = 0;
  int pops [2], vcnt [2], ovr_cnt [2], exp_ovr [2];
  logic [9:0] last [2], held [2];
  logic [1:0] hold, ovp;
  logic [9:0] qn [$], qe [$];
  logic [9:0] cur_c, exp_c;
  bit ok_c;
  always #5 clk = ~clk;
  usart_rx_os_if #(.DATA_BITS(8)) if_n ();
  usart_rx_os_if #(.DATA_BITS(8)) if_e ();
  assign if_n.data_ready = rdy[0];
  assign if_e.data_ready = rdy[1];
  assign dout[0] = if_n.data_out;
  assign dout[1] = if_e.data_out;
  assign pe = {if_e.parity_err, if_n.parity_err};
  assign fe = {if_e.frame_err, if_n.frame_err};
  assign valid = {if_e.data_valid, if_n.data_valid};
  usart_rx_os #(.CLK_FREQ(18432000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_n (.clk(clk), .reset(reset), .rx(rx[0]), .rx_if(if_n),
    .overrun(ovr[0]), .busy(busy[0]));
  usart_rx_os #(.CLK_FREQ(18432000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_e (.clk(clk), .reset(reset), .rx(rx[1]), .rx_if(if_e),
    .overrun(ovr[1]), .busy(busy[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_push(input int ln, input logic [9:0] e);
    if (mode[ln] == 0 && (ln == 0 ? qn.size() : qe.size()) >= 4) exp_ovr[ln]++;
    else if (ln == 0) qn.push_back(e);
    else qe.push_back(e);
  endtask
  task automatic model_pop(input int ln, output logic [9:0] e, output bit ok);
    ok = (ln == 0 ? qn.size() : qe.size()) != 0;
    e = '0;
    if (ok) e = (ln == 0) ? qn.pop_front() : qe.pop_front();
  endtask
  task automatic bit_out(input int ln, input logic v);
    rx[ln] = v;
    repeat (BIT) @(posedge clk);
  endtask
  task automatic send(input int ln, input logic [7:0] d, input bit fp, input bit bs, input bit keep);
    bit_out(ln, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(ln, d[i]);
    if (ln == 1) bit_out(ln, (^d) ^ fp);
    if (keep) model_push(ln, {bs, fp, d});
    bit_out(ln, !bs);
    rx[ln] = 1'b1;
  endtask
  task automatic wait_pop(input int ln, input int p);
    for (int i = 0; i < 400 && pops[ln] == p; i++) @(posedge clk);
    chk("pop_timeout", 32'(pops[ln] != p), 32'd1);
  endtask
  task automatic rand_line(input int ln);
    int gap;
    bit fp, bs;
    for (int k = 0; k < 10; k++) begin
      fp = ln == 1 && $urandom_range(0, 3) == 0;
      bs = $urandom_range(0, 5) == 0;
      send(ln, 8'($urandom), fp, bs, 1'b1);
      gap = ($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 300)) + (bs ? BIT : 0);
      repeat (gap) @(posedge clk);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) rdy[l] = mode[l] == 0 ? 1'b0 : mode[l] == 1 ? 1'b1 : 1'($urandom_range(0, 1));
  end
  // scoreboard: every accepted head must be the oldest expected word; held heads must not move
  initial forever begin
    @(negedge clk);
    if (reset) begin
      hold = '0;
      ovp = '0;
    end else for (int l = 0; l < 2; l++) begin
      cur_c = {fe[l], pe[l], dout[l]};
      if (valid[l] && rdy[l]) begin
        model_pop(l, exp_c, ok_c);
        checks++;
        if (!ok_c || cur_c !== exp_c) begin
          errors++;
          $display("FAIL pop%0d: got %0h expected %0h (model had entry=%0b)", l, cur_c, exp_c, ok_c);
        end
        last[l] = cur_c;
        pops[l]++;
      end
      if (hold[l]) begin
        checks++;
        if (!valid[l] || cur_c !== held[l]) begin
          errors++;
          $display("FAIL hold%0d: got valid=%0b head=%0h expected valid=1 head=%0h", l, valid[l], cur_c, held[l]);
        end
      end
      if (ovr[l]) begin
        ovr_cnt[l]++;
        checks++;
        if (ovp[l]) begin
          errors++;
          $display("FAIL ovr_width%0d: got pulse longer than 1 cycle expected 1 cycle", l);
        end
      end
      if (valid[l]) vcnt[l]++;
      hold[l] = valid[l] && !rdy[l];
      held[l] = cur_c;
      ovp[l] = ovr[l];
    end
  end
  initial begin
    int p, v;
    rx = 2'b11;
    mode = '{1, 1};
    pops = '{0, 0};
    vcnt = '{0, 0};
    ovr_cnt = '{0, 0};
    exp_ovr = '{0, 0};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 2; l++) chk("reset_outputs", 32'({dout[l], pe[l], fe[l], valid[l], ovr[l], busy[l]}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    p = pops[0];
    v = vcnt[0];
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_pop(0, p);
    chk("a5_entry", 32'(last[0]), 32'h0A5);
    chk("a5_valid_cycles", 32'(vcnt[0] - v), 32'd1);
    p = pops[1];
    send(1, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_pop(1, p);
    chk("e_parity_good", 32'(last[1]), 32'h003);
    p = pops[1];
    send(1, 8'h03, 1'b1, 1'b0, 1'b1);
    wait_pop(1, p);
    chk("e_parity_bad", 32'(last[1]), 32'h103);
    p = pops[0];
    rx[0] = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_high", 32'(busy[0]), 32'd1);
    repeat (35) @(posedge clk);
    rx[0] = 1'b1;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_low", 32'(busy[0]), 32'd0);
    chk("glitch_no_entry", 32'(pops[0] - p), 32'd0);
    p = pops[0];
    model_push(0, 10'h200);
    rx[0] = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    @(negedge clk);
    chk("break_busy", 32'(busy[0]), 32'd1);
    chk("break_entries", 32'(pops[0] - p), 32'd1);
    chk("break_entry", 32'(last[0]), 32'h200);
    rx[0] = 1'b1;
    repeat (BIT) @(posedge clk);
    p = pops[0];
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_pop(0, p);
    chk("after_break", 32'(last[0]), 32'h03C);
    mode[0] = 0;
    repeat (3) @(posedge clk);
    v = ovr_cnt[0];
    for (int d = 1; d <= 5; d++) send(0, 8'(d), 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ovr_pulses", 32'(ovr_cnt[0] - v), 32'd1);
    chk("ovr_model", 32'(exp_ovr[0]), 32'd1);
    chk("ovr_head", 32'({valid[0], fe[0], pe[0], dout[0]}), 32'h401);
    p = pops[0];
    mode[0] = 1;
    for (int i = 0; i < 200 && pops[0] - p < 4; i++) @(posedge clk);
    chk("ovr_drain", 32'(pops[0] - p), 32'd4);
    chk("ovr_last", 32'(last[0]), 32'h004);
    mode[0] = 0;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 32'(valid[0]), 32'd1);
    fork
      send(0, 8'h55, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5 * BIT) @(posedge clk);
        #1 reset = 1'b1;
        qn.delete();
        qe.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_outputs", 32'({dout[0], pe[0], fe[0], valid[0], ovr[0], busy[0]}), 32'd0);
      end
    join
    @(posedge clk);
    #1 reset = 1'b0;
    mode[0] = 1;
    p = pops[0];
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_pop(0, p);
    repeat (BIT) @(posedge clk);
    chk("after_reset_only_5a", 32'(pops[0] - p), 32'd1);
    chk("after_reset_entry", 32'(last[0]), 32'h05A);
    mode = '{2, 2};
    fork
      rand_line(0);
      rand_line(1);
    join
    mode = '{1, 1};
    for (int i = 0; i < 3000 && (qn.size() != 0 || qe.size() != 0); i++) @(posedge clk);
    chk("drain_n", 32'(qn.size()), 32'd0);
    chk("drain_e", 32'(qe.size()), 32'd0);
    chk("overruns_n", 32'(ovr_cnt[0]), 32'(exp_ovr[0]));
    chk("overruns_e", 32'(ovr_cnt[1]), 32'(exp_ovr[1]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usart_rx_os.md
# usart_rx_os

Parametrised, oversampling USART receiver and the successor to the single-rate receiver in the serial subsystem. It synchronises the asynchronous `rx` line and validates the start bit. It majority-votes each bit at mid-period, supports 5–9 data bits, optional parity and 1/2 stop bits, and tags each received word with error flags. Words are buffered in a small first-word-fall-through FIFO with a valid/ready output, so the consumer can stall without losing back-to-back frames.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in baud
- `DATA_BITS`, 8, data bits per frame (5–9), LSB first
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `OVERSAMPLE`, 16, sample ticks per bit (even, ≥8)
- `FIFO_DEPTH`, 4, receive FIFO entries (power of two, ≥2)
- `clk`  in  1  system clock; the block uses one clock
- `reset`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial line, idle high
- `data_out`  out  DATA_BITS  FIFO head data word
- `parity_err`  out  1  parity error flag of the FIFO head entry
- `frame_err`  out  1  framing error flag of the FIFO head entry
- `data_valid`  out  1  FIFO not empty
- `data_ready`  in  1  consumer accepts the head entry
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
- `busy`  out  1  high while the receiver FSM is not in IDLE

## Operation
- Input synchroniser: 2-flop; both flops reset to 1. All logic uses the synchronised `rxs`.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; elaborate-time error if DIV<1.
  - A free-running counter emits a 1-cycle `tick` every DIV clocks.
- Bit sampling:
  - A per-bit tick counter runs 0..OVERSAMPLE-1.
  - Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, decided at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on `rxs`==0, go to START; clear the tick counter and resynchronise the tick generator.
  - START: if the voted bit is 1, treat it as a false start and return to IDLE; if 0, go to DATA at the end of the bit period.
  - DATA: shift in DATA_BITS voted bits, LSB first. Then go to PARITY if PARITY≠0, else to STOP.
  - PARITY: parity_err = voted bit ≠ expected. Expected bit: even parity → XOR of data; odd parity → inverted XOR.
  - STOP: evaluate each stop bit's vote; any 0 sets frame_err.
  - STOP, on the last stop bit's decision: push {frame_err, parity_err, data}.
  - STOP exit without frame error: go directly to IDLE at the decision tick, so back-to-back frames are accepted.
  - STOP exit with frame error: go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. This handles break conditions.
- Framing and parity errors do not discard a word: it is pushed with its flags.
- FIFO:
  - Pop on `data_valid && data_ready`.
  - A push when full is dropped and `overrun` pulses, unless a pop occurs the same cycle; then both proceed and there is no overrun.
  - A simultaneous push and pop on an empty FIFO is impossible, because a pop requires `data_valid`.
  - Head outputs (`data_out`, `parity_err`, `frame_err`) hold stable while `data_valid` is high and `data_ready` is low.
- Mid-frame reset: the frame in progress is discarded, the FIFO is emptied and the FSM returns to IDLE the next cycle. A frame already on the line is resynchronised at its next falling edge.

## Timing
- Reset values: `data_out`=0, `parity_err`=0, `frame_err`=0, `data_valid`=0, `overrun`=0, `busy`=0; FIFO empty; FSM in IDLE.
- Start detection latency: 2 clocks of synchroniser delay plus 1 clock to leave IDLE.
- `busy` rises 1 clock after `rxs` falls.
- FIFO write: on the clock after the tick where the last stop bit is decided.
- `data_valid`: rises 1 clock after the write (FWFT, registered count).
- `overrun`: pulses in the same cycle as the dropped write.
- Throughput: one frame per (1+DATA_BITS+(PARITY≠0)+STOP_BITS) bit periods, with no inter-frame gap required.
- Counter widths: DIV counter is $clog2(DIV+1) bits; tick counter is $clog2(OVERSAMPLE) bits; FIFO pointers are $clog2(FIFO_DEPTH)+1 bits.

## Structure
- Package `usart_pkg`:
  - parity mode constants PARITY_NONE/ODD/EVEN
  - rx FSM state encoding
  - function `baud_div(clk, baud, os)`
  - entry width constant DATA_BITS+2
- Sub-module `usart_sync_fifo`: parametrised width and depth, FWFT, full/empty outputs; reused by the transmitter.
- The synchroniser, tick generator and FSM stay inline.

## Test plan
Bench parameters for all scenarios: CLK_FREQ=18432000, BAUD_RATE=115200, OVERSAMPLE=16, so DIV=10.
- 8N1, send 0xA5 with `data_ready`=1 → one entry {data 0xA5, parity_err 0, frame_err 0}; `data_valid` high for 1 cycle.
- 8E1, send 0x03 with the correct parity bit 0, then with parity bit 1 → parity_err 0, then 1; data 0x03 both times.
- Glitch: `rx` low for 5 ticks only → no push; `busy` returns to 0 within 1 bit period.
- Break: `rx` low for 12 bit periods → one entry with data 0x00 and frame_err 1; no further entries until `rx` rises and a new start bit arrives.
- Overrun: FIFO_DEPTH=4, `data_ready`=0, 5 back-to-back frames 0x01–0x05 → one `overrun` pulse on frame 5; entries pop in order 0x01–0x04.
- Reset asserted mid-DATA of 0x55, then frame 0x5A → only 0x5A is received; all outputs are 0 the cycle after reset.
